stage_sequencer: RTL

Parametrised successor to the fixed six-stage instruction sequencer that drives the multi-cycle core (fetch/decode/read/execute/memory/write-back). It sequences N stages one-hot. Per-instruction stage skipping comes from the decoder's enable mask. It adds behaviour the current sequencer lacks: a per-stage watchdog timeout, sticky fault capture with the faulting stage index, a halt/resume handshake at instruction boundaries, and cycle/retired-instruction counters for the CSR block.

---
 rtl/stage_sequencer_if.sv | 39 +++
 rtl/stage_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer_if.sv
// Handshake bundle between the instruction sequencer and the multi-cycle core.
// The master modport is the sequencer side and the slave modport is the core or testbench side.
//   inputs to the sequencer : enabled_stages, stage_done, fault_in, halt_req, resume
//   outputs from sequencer  : stage_active, stage_index, retire, halted, fault, timeout_fault,
//                             fault_stage, cycle_count, instret_count
interface stage_sequencer_if #(
  parameter int unsigned NUM_STAGES  = 6,
  parameter int unsigned COUNT_WIDTH = 64
);
  localparam int unsigned IdxW = $clog2(NUM_STAGES);

  logic [NUM_STAGES-1:0]  enabled_stages;
  logic [NUM_STAGES-1:0]  stage_done;
  logic                   fault_in;
  logic                   halt_req;
  logic                   resume;

  logic [NUM_STAGES-1:0]  stage_active;
  logic [IdxW-1:0]        stage_index;
  logic                   retire;
  logic                   halted;
  logic                   fault;
  logic                   timeout_fault;
  logic [IdxW-1:0]        fault_stage;
  logic [COUNT_WIDTH-1:0] cycle_count;
  logic [COUNT_WIDTH-1:0] instret_count;

  modport master (
    input  enabled_stages, stage_done, fault_in, halt_req, resume,
    output stage_active, stage_index, retire, halted, fault, timeout_fault, fault_stage,
           cycle_count, instret_count
  );

  modport slave (
    output enabled_stages, stage_done, fault_in, halt_req, resume,
    input  stage_active, stage_index, retire, halted, fault, timeout_fault, fault_stage,
           cycle_count, instret_count
  );
endinterface

// File: rtl/stage_sequencer.sv
// One-hot sequencer for the stages of a multi-cycle core. It supports per-instruction stage
// skipping, a per-stage watchdog, sticky fault capture, halt and resume at instruction
// boundaries, and cycle and instret counters.
//   clk   : clock; all state changes on the rising edge
//   reset : asynchronous, active-high
//   bus   : stage_sequencer_if.master (decode enables, stage completion, fault, halt and resume
//           in; active stage, retire, status and counters out, all registered)
module stage_sequencer #(
  parameter int unsigned NUM_STAGES     = 6,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned COUNT_WIDTH    = 64
) (
  input logic               clk,
  input logic               reset,
  stage_sequencer_if.master bus
);
  localparam int unsigned IdxW   = $clog2(NUM_STAGES);
  localparam int unsigned WdNeed = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned WdW    = (WdNeed > 8) ? WdNeed : 8;
  // Only used when TIMEOUT_CYCLES != 0, so the wrap for 0 is harmless.
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_STAGES-1:0] Stage0 = NUM_STAGES'(1);

  typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

  state_e                 state_q, state_d;
  logic [NUM_STAGES-1:0]  active_q, active_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [WdW-1:0]         wd_q, wd_d;
  logic                   retire_q, retire_d;
  logic                   halted_q, halted_d;
  logic                   fault_q, fault_d;
  logic                   to_fault_q, to_fault_d;
  logic [IdxW-1:0]        fault_stage_q, fault_stage_d;
  logic [COUNT_WIDTH-1:0] cycle_q, cycle_d;
  logic [COUNT_WIDTH-1:0] instret_q, instret_d;

  logic                   nxt_found;
  logic [IdxW-1:0]        nxt_idx;
  logic                   done_act;

  assign done_act = bus.stage_done[idx_q];

  // Lowest enabled stage above the active one; scanning downward lets the lowest hit win.
  always_comb begin
    nxt_found = 1'b0;
    nxt_idx   = '0;
    for (int j = NUM_STAGES - 1; j >= 1; j--) begin
      if (IdxW'(j) > idx_q && bus.enabled_stages[j]) begin
        nxt_found = 1'b1;
        nxt_idx   = IdxW'(j);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    active_d      = active_q;
    idx_d         = idx_q;
    wd_d          = wd_q;
    retire_d      = 1'b0;
    halted_d      = halted_q;
    fault_d       = fault_q;
    to_fault_d    = to_fault_q;
    fault_stage_d = fault_stage_q;
    cycle_d       = cycle_q;
    instret_d     = instret_q;

    unique case (state_q)
      StIdle: begin
        state_d  = StRun;
        active_d = Stage0;
        idx_d    = '0;
        wd_d     = '0;
      end
      StRun: begin
        cycle_d = cycle_q + COUNT_WIDTH'(1);
        if (bus.fault_in || (TIMEOUT_CYCLES != 0 && wd_q == WdLast && !done_act)) begin
          state_d       = StHalt;
          fault_d       = 1'b1;
          to_fault_d    = to_fault_q | ~bus.fault_in;
          fault_stage_d = idx_q;
          halted_d      = 1'b1;
          active_d      = '0;
          idx_d         = '0;
          wd_d          = '0;
        end else if (done_act) begin
          wd_d = '0;
          if (nxt_found) begin
            idx_d    = nxt_idx;
            active_d = Stage0 << nxt_idx;
          end else begin
            // Instruction boundary: retire, then either halt or refetch.
            retire_d  = 1'b1;
            instret_d = instret_q + COUNT_WIDTH'(1);
            idx_d     = '0;
            if (bus.halt_req) begin
              state_d  = StHalt;
              halted_d = 1'b1;
              active_d = '0;
            end else begin
              active_d = Stage0;
            end
          end
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      StHalt: begin
        // A faulted halt is locked until reset.
        if (!fault_q && bus.resume) begin
          state_d  = StRun;
          halted_d = 1'b0;
          active_d = Stage0;
          idx_d    = '0;
          wd_d     = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      active_q      <= '0;
      idx_q         <= '0;
      wd_q          <= '0;
      retire_q      <= 1'b0;
      halted_q      <= 1'b0;
      fault_q       <= 1'b0;
      to_fault_q    <= 1'b0;
      fault_stage_q <= '0;
      cycle_q       <= '0;
      instret_q     <= '0;
    end else begin
      state_q       <= state_d;
      active_q      <= active_d;
      idx_q         <= idx_d;
      wd_q          <= wd_d;
      retire_q      <= retire_d;
      halted_q      <= halted_d;
      fault_q       <= fault_d;
      to_fault_q    <= to_fault_d;
      fault_stage_q <= fault_stage_d;
      cycle_q       <= cycle_d;
      instret_q     <= instret_d;
    end
  end

  assign bus.stage_active  = active_q;
  assign bus.stage_index   = idx_q;
  assign bus.retire        = retire_q;
  assign bus.halted        = halted_q;
  assign bus.fault         = fault_q;
  assign bus.timeout_fault = to_fault_q;
  assign bus.fault_stage   = fault_stage_q;
  assign bus.cycle_count   = cycle_q;
  assign bus.instret_count = instret_q;
endmodule
